// File: rtl/core_ctrl.sv
// Multi-cycle sequencing controller for the single-issue RV32 core.
// It owns the PC, runs the fetch handshake and halts or traps the core.
module core_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    output logic        ir_wen,
    input  logic        dec_illegal,
    input  logic        dec_ebreak,
    input  logic        dec_rd_wen,
    input  logic [31:0] next_pc,
    output logic        rf_wen,
    output logic [31:0] pc,
    output logic        halt,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_WB,
        S_HALT,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_MISALGN = 2'd3
    } cause_e;

    localparam logic [15:0] TMO_LIMIT = 16'(FETCH_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;
    logic        halt_q, halt_d;
    logic        trap_q, trap_d;
    cause_e      cause_q, cause_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        pc_d      = pc_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;
        halt_d    = halt_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        imem_req  = 1'b0;
        ir_wen    = 1'b0;
        rf_wen    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                tmo_d    = 16'd0;
                cycle_d  = cycle_q + 32'd1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                cycle_d = cycle_q + 32'd1;
                // A response on the limit cycle still wins over the timeout.
                if (imem_rvalid) begin
                    ir_wen  = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                    if (tmo_d == TMO_LIMIT) begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            S_EXEC: begin
                cycle_d = cycle_q + 32'd1;
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_d   = S_HALT;
                    halt_d    = 1'b1;
                    instret_d = instret_q + 32'd1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                cycle_d = cycle_q + 32'd1;
                if (next_pc[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_MISALGN;
                end else begin
                    rf_wen    = dec_rd_wen;
                    pc_d      = next_pc;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            default: ;
        endcase

        // Reset drops any strobe, including a write pending in WB.
        if (rst) begin
            imem_req = 1'b0;
            ir_wen   = 1'b0;
            rf_wen   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            tmo_q     <= 16'd0;
            pc_q      <= RESET_PC;
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
            halt_q    <= 1'b0;
            trap_q    <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            pc_q      <= pc_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            halt_q    <= halt_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign halt        = halt_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencing controller for the single-issue RV32 core. It owns the program counter, drives the instruction-fetch handshake, and tells the datapath when to latch the instruction and when to commit register-file writes and the next PC. It stops the core on `ebreak` (halt) or on a fault (trap), and keeps cycle and retired-instruction counters. It sits in `top` between instruction memory, the decode stage and the register file/PC write ports.

## Interface
- `RESET_PC`, default 32'h80000000, PC value loaded on reset.
- `FETCH_TIMEOUT`, default 255, maximum number of WAIT cycles without `imem_rvalid` before a trap; range 1..65535.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request strobe.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_rvalid` in 1: instruction data valid.
- `ir_wen` out 1: latch `imem_rdata` into the instruction register.
- `dec_illegal` in 1: decode flags an unsupported encoding. Valid in EXEC.
- `dec_ebreak` in 1: decode flags `ebreak`. Valid in EXEC.
- `dec_rd_wen` in 1: the instruction writes `rd`. Valid in EXEC and WB.
- `next_pc` in 32: next PC computed by the datapath (pc+4 or jump target). Valid in WB.
- `rf_wen` out 1: register-file write strobe.
- `pc` out 32: current PC.
- `halt` out 1: sticky; set by `ebreak`.
- `trap` out 1: sticky; set by a fault.
- `trap_cause` out 2: 0 none, 1 illegal instruction, 2 fetch timeout, 3 misaligned `next_pc`.
- `cycle_cnt` out 32: counts running cycles.
- `instret_cnt` out 32: counts retired instructions.

## Operation
- States: FETCH, WAIT, EXEC, WB, HALT, TRAP. The reset state is FETCH.
- **FETCH:** `imem_req`=1 for exactly one cycle. The timeout counter clears. Next state is WAIT.
- **WAIT:**
  - If `imem_rvalid`=1: `ir_wen`=1 in that same cycle; go to EXEC.
  - Otherwise the timeout counter increments. When it reaches `FETCH_TIMEOUT`, go to TRAP with cause 2.
  - `imem_rvalid` is ignored in every state other than WAIT.
- **EXEC:** priority is `dec_illegal` > `dec_ebreak`.
  - `dec_illegal` → TRAP, cause 1.
  - `dec_ebreak` → HALT. The instruction retires: `instret_cnt`+1, and `pc` is unchanged.
  - Otherwise → WB.
- **WB:**
  - If `next_pc[1:0]`≠0: go to TRAP with cause 3. No register-file write, and `pc` is unchanged.
  - Otherwise: `rf_wen`=`dec_rd_wen`, `pc`←`next_pc`, `instret_cnt`+1, and go to FETCH.
  - Writes to x0 are suppressed by the register file, not here.
- **HALT / TRAP:** terminal. All strobes are 0 and counters freeze. Only `rst` exits.
- `cycle_cnt` increments every cycle in FETCH, WAIT, EXEC and WB. Both counters wrap modulo 2^32 with no flag.
- `trap_cause` is written only on entry to TRAP. It is 0 in every other state.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`
  - `imem_req`=`ir_wen`=`rf_wen`=0
  - `halt`=`trap`=0
  - `trap_cause`=0
  - both counters 0
  - state FETCH
- **Strobes during reset:** all strobes are forced to 0 while `rst`=1. `rst` takes priority over every transition, including HALT and TRAP, and over reset mid-instruction; any pending write is dropped.
- **Output timing:** strobes are decoded from the registered state, gated only by `imem_rvalid` (for `ir_wen`) and `dec_rd_wen` (for `rf_wen`). `pc`, `halt`, `trap`, `trap_cause` and both counters are registered.
- **Latency:** one instruction takes 4 cycles when `rvalid` arrives in the first WAIT cycle (FETCH, WAIT, EXEC, WB), plus 1 cycle per extra WAIT cycle.
- **`imem_rvalid` in FETCH:** a value of 1 in FETCH is ignored. The memory must respond no earlier than the cycle after `imem_req`.
- **Timeout boundary:** if `rvalid` arrives in the same cycle the counter would hit `FETCH_TIMEOUT`, `rvalid` wins and the fetch succeeds.
- **`halt` / `trap` assertion:** each rises in the first cycle of HALT or TRAP respectively. They are never both 1.

## Test plan
- **Reset then sequential fetch:** release `rst`; memory answers 1 cycle after each request; decode flags are 0 and `next_pc`=`pc`+4. Required: `imem_addr` sequence 0x80000000, 0x80000004, 0x80000008; `imem_req` every 4th cycle; `instret_cnt`=3 and `cycle_cnt`=12 after 12 cycles.
- **Write-back gating:** `dec_rd_wen`=1 for the 1st instruction and 0 for the 2nd. Required: exactly one `rf_wen` pulse, in the WB cycle of the 1st instruction.
- **ebreak at 0x80000008:** assert `dec_ebreak` in EXEC for the third instruction. Required: `halt`=1, `pc` stays 0x80000008, `instret_cnt`=3, counters frozen for 20 further cycles, no `imem_req`.
- **Fetch timeout:** set `FETCH_TIMEOUT`=4 and never assert `rvalid`. Required: `trap`=1 with `trap_cause`=2 after exactly 4 WAIT cycles. A second run with `rvalid` on the 4th WAIT cycle must proceed normally.
- **Illegal and misaligned:** `dec_illegal`=1 gives `trap_cause`=1 and no `rf_wen`. `next_pc`=0x80000006 in WB gives `trap_cause`=3, `pc` unchanged and no `rf_wen`.
- **Reset mid-instruction:** assert `rst` in WB with `dec_rd_wen`=1. Required: no `rf_wen`, and all outputs equal the reset values on the next cycle. Repeat from the HALT and TRAP states.
